// File: rtl/rename_table_mp_if.sv
// Bundle of dispatch, broadcast and operand-packet signals for rename_table_mp.
// The table side uses the slave modport; the dispatch/issue side uses master.
interface rename_table_mp_if #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 3,
    parameter int NUM_CDB  = 2,
    parameter int RW       = $clog2(NUM_REGS)
);
    // Handshake: a dispatch port N is taken on a rising edge when dN_valid && disp_ready;
    // its operand packet appears on oN_* with oN_valid high for exactly the following cycle.
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_value;

    logic             d0_valid, d1_valid;
    logic [RW-1:0]    d0_rs1, d0_rs2, d0_rd;
    logic [RW-1:0]    d1_rs1, d1_rs2, d1_rd;
    logic [TAG_W-1:0] d0_tag, d1_tag;
    logic             disp_ready;

    logic              o0_valid, o1_valid;
    logic [TAG_W-1:0]  o0_tag, o1_tag;
    logic              o0_s1_rdy, o0_s2_rdy, o1_s1_rdy, o1_s2_rdy;
    logic [DATA_W-1:0] o0_s1_val, o0_s2_val, o1_s1_val, o1_s2_val;

    logic dbg_state;  // 0 = INIT, 1 = RUN

    modport master (
        output cdb_valid, cdb_tag, cdb_value,
        output d0_valid, d0_rs1, d0_rs2, d0_rd, d0_tag,
        output d1_valid, d1_rs1, d1_rs2, d1_rd, d1_tag,
        input  disp_ready,
        input  o0_valid, o0_tag, o0_s1_rdy, o0_s2_rdy, o0_s1_val, o0_s2_val,
        input  o1_valid, o1_tag, o1_s1_rdy, o1_s2_rdy, o1_s1_val, o1_s2_val,
        input  dbg_state
    );

    modport slave (
        input  cdb_valid, cdb_tag, cdb_value,
        input  d0_valid, d0_rs1, d0_rs2, d0_rd, d0_tag,
        input  d1_valid, d1_rs1, d1_rs2, d1_rd, d1_tag,
        output disp_ready,
        output o0_valid, o0_tag, o0_s1_rdy, o0_s2_rdy, o0_s1_val, o0_s2_val,
        output o1_valid, o1_tag, o1_s1_rdy, o1_s2_rdy, o1_s1_val, o1_s2_val,
        output dbg_state
    );
endinterface

// File: rtl/rename_table_mp.sv
// Two-wide register rename table with multi-bus CDB wakeup and registered operand packets.
// Optional feature macro RAT_FLUSH_EN adds a flush input that clears all pending renames.
module rename_table_mp #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 3,
    parameter int NUM_CDB  = 2,
    parameter int RW       = $clog2(NUM_REGS)
) (
    input  logic clk,
    input  logic rst_n,
    rename_table_mp_if.slave io
`ifdef RAT_FLUSH_EN
    ,input logic flush
`endif
);
    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] init_cnt;
    logic          flush_req;
    logic          flush_act;
    logic          acc0, acc1;

    logic              tbl_valid [NUM_REGS];
    logic [TAG_W-1:0]  tbl_tag   [NUM_REGS];
    logic [DATA_W-1:0] tbl_value [NUM_REGS];

    logic              wake_hit [NUM_REGS];
    logic [DATA_W-1:0] wake_val [NUM_REGS];

    logic [RW-1:0]     src_rs  [4];
    logic              src_rdy [4];
    logic [DATA_W-1:0] src_val [4];

`ifdef RAT_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif
    assign flush_act = flush_req && (state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && init_cnt == RW'(NUM_REGS - 1)) state_nxt = S_RUN;
    end

    always_comb begin
        io.disp_ready = (state == S_RUN) && !flush_req;
        io.dbg_state  = state;
    end

    assign acc0 = io.d0_valid && io.disp_ready;
    assign acc1 = io.d1_valid && io.disp_ready;

    // Buses are scanned from the top down so the lowest-indexed matching bus wins.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            wake_hit[i] = 1'b0;
            wake_val[i] = '0;
            for (int b = NUM_CDB - 1; b >= 0; b--) begin
                if (io.cdb_valid[b] && !tbl_valid[i] &&
                    io.cdb_tag[b*TAG_W +: TAG_W] == tbl_tag[i]) begin
                    wake_hit[i] = 1'b1;
                    wake_val[i] = io.cdb_value[b*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Sources 2/3 belong to port 1 and see port 0's same-cycle rename first.
    always_comb begin
        src_rs[0] = io.d0_rs1;
        src_rs[1] = io.d0_rs2;
        src_rs[2] = io.d1_rs1;
        src_rs[3] = io.d1_rs2;
        for (int k = 0; k < 4; k++) begin
            src_rdy[k] = 1'b1;
            src_val[k] = '0;
            if (src_rs[k] == '0) begin
                src_rdy[k] = 1'b1;
                src_val[k] = '0;
            end else if (k >= 2 && acc0 && src_rs[k] == io.d0_rd) begin
                src_rdy[k] = 1'b0;
                src_val[k] = DATA_W'(io.d0_tag);
            end else if (wake_hit[src_rs[k]]) begin
                src_rdy[k] = 1'b1;
                src_val[k] = wake_val[src_rs[k]];
            end else if (tbl_valid[src_rs[k]]) begin
                src_rdy[k] = 1'b1;
                src_val[k] = tbl_value[src_rs[k]];
            end else begin
                src_rdy[k] = 1'b0;
                src_val[k] = DATA_W'(tbl_tag[src_rs[k]]);
            end
        end
    end

    // Table contents need no reset: INIT rewrites every entry before dispatch opens.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            tbl_valid[init_cnt] <= 1'b1;
            tbl_tag[init_cnt]   <= '0;
            tbl_value[init_cnt] <= DATA_W'(init_cnt);
        end else if (flush_act) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tbl_valid[i] <= 1'b1;
                tbl_tag[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wake_hit[i]) begin
                    tbl_valid[i] <= 1'b1;
                    tbl_tag[i]   <= '0;
                    tbl_value[i] <= wake_val[i];
                end
            end
            // Later assignments win: port 1 over port 0, renames over wakeups.
            if (acc0 && io.d0_rd != '0) begin
                tbl_valid[io.d0_rd] <= 1'b0;
                tbl_tag[io.d0_rd]   <= io.d0_tag;
                tbl_value[io.d0_rd] <= '0;
            end
            if (acc1 && io.d1_rd != '0) begin
                tbl_valid[io.d1_rd] <= 1'b0;
                tbl_tag[io.d1_rd]   <= io.d1_tag;
                tbl_value[io.d1_rd] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.o0_valid  <= 1'b0;
            io.o0_tag    <= '0;
            io.o0_s1_rdy <= 1'b0;
            io.o0_s2_rdy <= 1'b0;
            io.o0_s1_val <= '0;
            io.o0_s2_val <= '0;
            io.o1_valid  <= 1'b0;
            io.o1_tag    <= '0;
            io.o1_s1_rdy <= 1'b0;
            io.o1_s2_rdy <= 1'b0;
            io.o1_s1_val <= '0;
            io.o1_s2_val <= '0;
        end else begin
            io.o0_valid <= acc0;
            io.o1_valid <= acc1;
            if (acc0) begin
                io.o0_tag    <= io.d0_tag;
                io.o0_s1_rdy <= src_rdy[0];
                io.o0_s2_rdy <= src_rdy[1];
                io.o0_s1_val <= src_val[0];
                io.o0_s2_val <= src_val[1];
            end
            if (acc1) begin
                io.o1_tag    <= io.d1_tag;
                io.o1_s1_rdy <= src_rdy[2];
                io.o1_s2_rdy <= src_rdy[3];
                io.o1_s1_val <= src_val[2];
                io.o1_s2_val <= src_val[3];
            end
        end
    end
endmodule
